// File: rtl/mux_sel_arb.sv
// Round-robin 5:1 mux-select arbiter with minimum dwell and forced release at MAX_HOLD.
// Latency: request sampled at edge N gives a registered sel/sel_vld after edge N; one idle cycle between grants.
// Backpressure: none; done releases a grant only after MIN_DWELL, and en gates new grants only.
module mux_sel_arb #(
    parameter int MIN_DWELL = 2,
    parameter int MAX_HOLD  = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       sel_vld,
    output logic       busy,
    output logic       gnt_timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] MAX_H = CNT_W'(MAX_HOLD);
    localparam logic [2:0]       LAST_CH = 3'd4;

    logic [0:0]       state;
    logic [CNT_W-1:0] dwell_cnt;
    logic [2:0]       last;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [3:0]       sum;
    logic [2:0]       cand;

    logic             rel_drop;
    logic             rel_done;
    logic             rel_max;
    logic             release_now;
    logic             timeout_hit;

    // Search order starts one past the last winner, wrapping 4 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        sum       = 4'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            sum = {1'b0, last} + 4'(i);
            if (sum >= 4'd5) begin
                sum = sum - 4'd5;
            end
            cand = sum[2:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release causes in priority order; timeout only flags the MAX_HOLD-only case.
    always_comb begin
        rel_drop    = !req[sel];
        rel_done    = done && (dwell_cnt >= MIN_D);
        rel_max     = (dwell_cnt == MAX_H);
        release_now = rel_drop || rel_done || rel_max;
        timeout_hit = rel_max && !rel_drop && !rel_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= 3'd0;
            sel_vld     <= 1'b0;
            busy        <= 1'b0;
            gnt_timeout <= 1'b0;
            dwell_cnt   <= '0;
            last        <= LAST_CH;
        end else begin
            gnt_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && win_found) begin
                        state     <= ST_GRANT;
                        sel       <= win_idx;
                        sel_vld   <= 1'b1;
                        busy      <= 1'b1;
                        dwell_cnt <= CNT_W'(1);
                        last      <= win_idx;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state       <= ST_IDLE;
                        sel_vld     <= 1'b0;
                        busy        <= 1'b0;
                        gnt_timeout <= timeout_hit;
                        dwell_cnt   <= '0;
                    end else if (dwell_cnt != MAX_H) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_sel_arb.md
MUX_SEL_ARB -- requirements
Module: mux_sel_arb

Interface
REQ-001 Parameter MIN_DWELL, default 2, minimum GRANT cycles before done may release; legal range 1..MAX_HOLD.
REQ-002 Parameter MAX_HOLD, default 16, GRANT cycle count at which a grant is forcibly released; legal range MIN_DWELL..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 5, width of the dwell counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  enables new grants; does not abort a grant in progress.
REQ-007 req  input  5  per-channel request, bit k = channel k (k = 0..4).
REQ-008 done  input  1  consumer indicates it has finished with the granted channel.
REQ-009 sel  output  3  registered index of the granted channel; drives the downstream 5:1 mux select.
REQ-010 sel_vld  output  1  registered; high while sel is a live grant.
REQ-011 busy  output  1  registered; high in GRANT state (equal to sel_vld).
REQ-012 gnt_timeout  output  1  registered one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 sel SHALL only ever carry values 0..4; values 5..7 are never driven, including after reset.
REQ-015 In IDLE, when en=1 and req!=0 at an edge, the block SHALL enter GRANT at that edge with sel = winner, sel_vld=1, dwell_cnt=1.
REQ-016 Winner selection: round-robin search starting at (last+1) mod 5, wrapping 4->0; first channel with req bit set wins.
REQ-017 last SHALL update to the granted index when the grant is issued.
REQ-018 In IDLE with en=0 or req=0, state and all outputs SHALL hold; sel keeps its previous value with sel_vld=0.
REQ-019 In GRANT, dwell_cnt SHALL increment by 1 per cycle, saturating at MAX_HOLD.
REQ-020 Release conditions, evaluated at each GRANT edge, priority order: (a) req[sel]=0 -> release; (b) done=1 and dwell_cnt>=MIN_DWELL -> release; (c) dwell_cnt==MAX_HOLD -> release with gnt_timeout=1.
REQ-021 done=1 with dwell_cnt<MIN_DWELL SHALL be ignored (not latched).
REQ-022 gnt_timeout SHALL pulse only for release (c), never when (a) or (b) holds in the same cycle.
REQ-023 On release the block SHALL return to IDLE with sel_vld=0, busy=0; sel unchanged.
REQ-024 After any release, IDLE SHALL last at least one cycle (one-cycle gap between consecutive grants).
REQ-025 en deasserted during GRANT SHALL NOT shorten the grant; it only blocks the next grant.
REQ-026 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-027 Grant latency: req sampled at edge N -> sel/sel_vld valid after edge N (visible cycle N+1).

Reset
REQ-028 When rst=1 at an edge: state=IDLE, sel=0, sel_vld=0, busy=0, gnt_timeout=0, dwell_cnt=0, last=4 (so channel 0 has first priority).
REQ-029 rst SHALL override all other inputs, including mid-GRANT; an in-progress grant is dropped with no gnt_timeout pulse.
REQ-030 On the first edge after rst deasserts, normal IDLE evaluation SHALL apply.

Verification
REQ-031 Reset then req=5'b11111, en=1, done asserted each cycle after MIN_DWELL -> sel sequence 0,1,2,3,4,0 with one idle cycle between grants.
REQ-032 req=5'b00100 only, done never asserted -> sel=2 for 16 cycles, gnt_timeout=1 on cycle 16 release, sel_vld=0 next cycle, regrant to 2 after one-cycle gap.
REQ-033 Grant to ch1 (req=5'b00010), done=1 at dwell_cnt=1 -> ignored; done=1 at dwell_cnt=2 -> released, gnt_timeout=0.
REQ-034 Grant to ch3, drop req[3] at dwell_cnt=1 -> released next edge, no timeout; with req=5'b10001 next grant is ch4 (wrap order 4 before 0).
REQ-035 rst=1 asserted at dwell_cnt=5 of a ch4 grant -> next cycle sel=0, sel_vld=0, gnt_timeout=0; first post-reset grant with req=5'b10001 is ch0.
REQ-036 en=0 with req=5'b11111 for 10 cycles -> sel_vld stays 0; random stimulus check: sel never in 5..7, sel_vld never high two grants without an intervening low cycle.
